countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer_if.sv | 26 ++
 rtl/countdown_timer.sv | 134 +++++++++++++
 tb/tb_countdown_timer.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// Control and display bundle of the countdown timer: stimulus from the controller side,
// BCD digits and status from the timer side.
interface countdown_timer_if;
  logic        tick;
  logic        load;
  logic        start;
  logic        stop;
  logic [15:0] preset;
  logic [3:0]  digit0;
  logic [3:0]  digit1;
  logic [3:0]  digit2;
  logic [3:0]  digit3;
  logic        running;
  logic        done;
  logic        expired;

  modport master (
    output tick, load, start, stop, preset,
    input  digit0, digit1, digit2, digit3, running, done, expired
  );

  modport slave (
    input  tick, load, start, stop, preset,
    output digit0, digit1, digit2, digit3, running, done, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// BCD countdown timer, 0:00.0 to 9:59.9 in tenth-second ticks, with optional auto-reload.
//   state   | meaning
//   IDLE    | count loaded or reset, waiting for start
//   RUN     | decrementing on each tick
//   PAUSE   | stopped mid-count, start resumes
//   EXPIRED | reached 0:00.0, only load or reset leaves
module countdown_timer #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  countdown_timer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] reload_q, reload_d;
  logic        done_q, done_d;
  logic        running_q, running_d;
  logic        expired_q, expired_d;
  logic [15:0] dec_cnt;

  function automatic logic [15:0] clamp_bcd(input logic [15:0] p);
    logic [15:0] r;
    r[15:12] = (p[15:12] > 4'd9) ? 4'd9 : p[15:12];
    r[11:8]  = (p[11:8]  > 4'd5) ? 4'd5 : p[11:8];
    r[7:4]   = (p[7:4]   > 4'd9) ? 4'd9 : p[7:4];
    r[3:0]   = (p[3:0]   > 4'd9) ? 4'd9 : p[3:0];
    return r;
  endfunction

  // Only used on a nonzero count, so the minutes digit never underflows.
  function automatic logic [15:0] dec_bcd(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd9;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd5;
          r[15:12] = c[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign dec_cnt = dec_bcd(cnt_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (bus.load) begin
      cnt_d    = clamp_bcd(bus.preset);
      reload_d = clamp_bcd(bus.preset);
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start && (cnt_q != 16'h0000)) state_d = RUN;
        end
        PAUSE: begin
          if (bus.start) state_d = RUN;
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (bus.tick) begin
            if (dec_cnt == 16'h0000) begin
              done_d = 1'b1;
              if (AUTO_RELOAD && (reload_q != 16'h0000)) begin
                cnt_d = reload_q;
              end else begin
                cnt_d   = 16'h0000;
                state_d = EXPIRED;
              end
            end else begin
              cnt_d = dec_cnt;
            end
          end
        end
        EXPIRED: begin
          state_d = EXPIRED;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
    expired_d = (state_d == EXPIRED);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= 16'h0000;
      reload_q  <= 16'h0000;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      running_q <= running_d;
      expired_q <= expired_d;
    end
  end

  assign bus.digit0  = cnt_q[3:0];
  assign bus.digit1  = cnt_q[7:4];
  assign bus.digit2  = cnt_q[11:8];
  assign bus.digit3  = cnt_q[15:12];
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.expired = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Table-driven bench for countdown_timer: one instance without and one with auto-reload,
// expected values queued when a vector is driven and compared after the clock edge.
module tb_countdown_timer;

  typedef struct {
    logic        ld, st, sp, tk;
    logic [15:0] pre;
    logic [15:0] cnt;
    logic        run, dn, ex;
    string       nm;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  vec_t tab0[$];
  vec_t tab1[$];
  vec_t exp_q[$];

  countdown_timer_if if0 ();
  countdown_timer_if if1 ();

  countdown_timer #(.AUTO_RELOAD(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(if0));
  countdown_timer #(.AUTO_RELOAD(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(if1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] to_bcd(input int t);
    logic [15:0] r;
    r[15:12] = 4'(t / 600);
    r[11:8]  = 4'((t % 600) / 100);
    r[7:4]   = 4'((t % 100) / 10);
    r[3:0]   = 4'(t % 10);
    return r;
  endfunction

  function void add(input int which, input logic ld, st, sp, tk, input logic [15:0] pre,
                    input logic [15:0] cnt, input logic run, dn, ex, input string nm);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.tk = tk; v.pre = pre;
    v.cnt = cnt; v.run = run; v.dn = dn; v.ex = ex; v.nm = nm;
    if (which == 0) tab0.push_back(v);
    else            tab1.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic actual(input int which, output logic [15:0] cnt, output logic run, dn, ex);
    if (which == 0) begin
      cnt = {if0.digit3, if0.digit2, if0.digit1, if0.digit0};
      run = if0.running; dn = if0.done; ex = if0.expired;
    end else begin
      cnt = {if1.digit3, if1.digit2, if1.digit1, if1.digit0};
      run = if1.running; dn = if1.done; ex = if1.expired;
    end
  endtask

  task automatic drive(input int which, input logic ld, st, sp, tk, input logic [15:0] pre);
    if (which == 0) begin
      if0.load = ld; if0.start = st; if0.stop = sp; if0.tick = tk; if0.preset = pre;
    end else begin
      if1.load = ld; if1.start = st; if1.stop = sp; if1.tick = tk; if1.preset = pre;
    end
  endtask

  task automatic step(input int which, input vec_t v);
    vec_t        e;
    logic [15:0] cnt;
    logic        run, dn, ex;
    @(negedge clock);
    drive(which, v.ld, v.st, v.sp, v.tk, v.pre);
    exp_q.push_back(v);
    @(posedge clock);
    #1;
    e = exp_q.pop_front();
    actual(which, cnt, run, dn, ex);
    chk({e.nm, " count"},   32'(cnt), 32'(e.cnt));
    chk({e.nm, " running"}, 32'(run), 32'(e.run));
    chk({e.nm, " done"},    32'(dn),  32'(e.dn));
    chk({e.nm, " expired"}, 32'(ex),  32'(e.ex));
    drive(which, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic check_zero(input string nm);
    logic [15:0] cnt;
    logic        run, dn, ex;
    for (int w = 0; w < 2; w++) begin
      actual(w, cnt, run, dn, ex);
      chk($sformatf("%s dut%0d count", nm, w), 32'(cnt), 32'h0);
      chk($sformatf("%s dut%0d flags", nm, w), 32'({run, dn, ex}), 32'h0);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    drive(1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // ---- vector tables ----
    add(0, 1, 0, 0, 0, 16'h0012, 16'h0012, 0, 0, 0, "load 1.2");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0012, 1, 0, 0, "start 1.2");
    for (int i = 1; i <= 12; i++)
      add(0, 0, 0, 0, 1, 16'h0000, to_bcd(12 - i), (i < 12), (i == 12), (i == 12),
          $sformatf("tick%0d of 1.2", i));
    add(0, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, "after expiry");
    add(0, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 1, "expired ignores");
    add(0, 1, 0, 0, 0, 16'h1000, 16'h1000, 0, 0, 0, "load 1:00.0");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h1000, 1, 0, 0, "start 1:00.0");
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0599, 1, 0, 0, "borrow to 0:59.9");
    add(0, 1, 0, 0, 0, 16'h0050, 16'h0050, 0, 0, 0, "load 0:05.0");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0050, 1, 0, 0, "start 0:05.0");
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0050, 0, 0, 0, "stop beats tick");
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0050, 0, 0, 0, "pause holds");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0050, 1, 0, 0, "resume");
    for (int i = 1; i <= 3; i++)
      add(0, 0, 0, 0, 1, 16'h0000, to_bcd(50 - i), 1, 0, 0, $sformatf("resume tick%0d", i));
    add(0, 1, 0, 0, 0, 16'hFAFF, 16'h9599, 0, 0, 0, "clamp FAFF");
    add(0, 1, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "load zero");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, "start on zero");
    add(0, 1, 0, 0, 0, 16'h0005, 16'h0005, 0, 0, 0, "load 0:00.5");
    add(0, 0, 1, 0, 1, 16'h0000, 16'h0005, 1, 0, 0, "start edge no dec");
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0004, 1, 0, 0, "first dec");
    add(0, 1, 1, 1, 1, 16'h0123, 16'h0123, 0, 0, 0, "load priority");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0123, 1, 0, 0, "start 0:12.3");
    for (int i = 1; i <= 24; i++)
      add(0, 0, 0, 0, 1, 16'h0000, to_bcd(123 - i), 1, 0, 0, $sformatf("run 12.3 tick%0d", i));
    add(0, 1, 0, 0, 0, 16'h0050, 16'h0050, 0, 0, 0, "reload 0:05.0");
    add(0, 0, 1, 0, 0, 16'h0000, 16'h0050, 1, 0, 0, "start before reset");
    add(0, 0, 0, 0, 1, 16'h0000, 16'h0049, 1, 0, 0, "tick before reset");

    add(1, 1, 0, 0, 0, 16'h0003, 16'h0003, 0, 0, 0, "ar load 0.3");
    add(1, 0, 1, 0, 0, 16'h0000, 16'h0003, 1, 0, 0, "ar start");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0, "ar tick1");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "ar tick2");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0003, 1, 1, 0, "ar tick3 reload");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0, "ar tick4");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0, "ar tick5");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0003, 1, 1, 0, "ar tick6 reload");
    add(1, 0, 0, 0, 1, 16'h0000, 16'h0002, 1, 0, 0, "ar tick7");
    add(1, 0, 0, 0, 0, 16'h0000, 16'h0002, 1, 0, 0, "ar idle cycle");

    // ---- reset state ----
    #12;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b1;

    foreach (tab0[i]) step(0, tab0[i]);

    // Reset asserted between edges while running must clear immediately.
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    check_zero("async reset");
    @(negedge clock);
    reset = 1'b1;
    begin
      vec_t v;
      v.ld = 0; v.st = 1; v.sp = 0; v.tk = 0; v.pre = 16'h0000;
      v.cnt = 16'h0000; v.run = 0; v.dn = 0; v.ex = 0; v.nm = "start after reset";
      step(0, v);
    end

    foreach (tab1[i]) step(1, tab1[i]);

    if (exp_q.size() != 0) chk("scoreboard drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
